// File: rtl/simple_io_port.sv
// simple_io_port: console I/O responder for the SIMPLE CPU.
// OUT values are queued for the board display and stepped through with a
// debounced pushbutton; IN requests capture the synchronized switch bank.
// Build option IO_OUT_FIFO_EN: defined gives a DEPTH-entry output FIFO,
// undefined gives a single holding register (effective depth 1).

module simple_io_port #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DEBOUNCE = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        out_en,
    input  logic [15:0] out_data,
    output logic        out_full,
    output logic        overflow,
    input  logic        in_req,
    output logic [15:0] in_data,
    output logic        in_valid,
    input  logic [15:0] sw,
    input  logic        next_btn,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    output logic [3:0]  out_count
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    // Reject illegal DEPTH values at elaboration, whichever OUT path is built.
    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("simple_io_port: DEPTH must be a power of 2 in 2..8");
    end

    logic [15:0] sw_m;
    logic [15:0] sw_s;
    logic        btn_m;
    logic        btn_s;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } db_state_t;

    db_state_t   db_state;
    logic [CW-1:0] cnt;
    logic        btn_lvl;
    logic        pop_req;

    logic        push;
    logic        pop;

    // Two-flop synchronizers for the asynchronous switch bank and button.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_m  <= '0;
            sw_s  <= '0;
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sw_m  <= sw;
            sw_s  <= sw_m;
            btn_m <= next_btn;
            btn_s <= btn_m;
        end
    end

    // Debounce: a new button level is accepted only after DEBOUNCE stable
    // cycles; pop_req pulses once on each accepted press (0->1).
    always_ff @(posedge clock) begin
        if (reset) begin
            db_state <= IDLE;
            cnt      <= '0;
            btn_lvl  <= 1'b0;
            pop_req  <= 1'b0;
        end else begin
            pop_req <= 1'b0;
            case (db_state)
                IDLE: begin
                    if (btn_s != btn_lvl) begin
                        db_state <= COUNT;
                        cnt      <= CW'(1);
                    end
                end
                COUNT: begin
                    if (btn_s == btn_lvl) begin
                        db_state <= IDLE;
                        cnt      <= '0;
                    end else if (cnt == CW'(DEBOUNCE)) begin
                        btn_lvl  <= btn_s;
                        pop_req  <= btn_s;
                        db_state <= IDLE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    db_state <= IDLE;
                    cnt      <= '0;
                end
            endcase
        end
    end

    // IN path: one-cycle in_valid pulse carrying the synchronized switches.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_data  <= '0;
            in_valid <= 1'b0;
        end else begin
            in_valid <= in_req;
            if (in_req) begin
                in_data <= sw_s;
            end
        end
    end

    // Sticky overflow: an OUT strobe whose push was rejected.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (out_en && !push) begin
            overflow <= 1'b1;
        end
    end

`ifdef IO_OUT_FIFO_EN

    localparam int unsigned PW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [3:0]    count;
    logic [3:0]    count_nxt;
    logic [15:0]   disp_nxt;

    assign pop  = pop_req && (count != '0);
    assign push = out_en && ((count < 4'(DEPTH)) || pop);

    assign out_full   = (count == 4'(DEPTH));
    assign disp_valid = (count != '0);
    assign out_count  = count;

    // Next head value for the registered display. When the new head is the
    // slot being written this cycle, forward out_data instead of stale mem.
    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
        count_nxt  = count;
        if (push && !pop) begin
            count_nxt = count + 4'd1;
        end else if (pop && !push) begin
            count_nxt = count - 4'd1;
        end
        disp_nxt = '0;
        if (count_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr)) begin
                disp_nxt = out_data;
            end else begin
                disp_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // FIFO storage; contents are unreachable after reset so are not cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= out_data;
        end
    end

    // FIFO pointers, occupancy and registered display head.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            disp_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            disp_data <= disp_nxt;
        end
    end

`else

    logic hold_valid;

    assign pop  = pop_req && hold_valid;
    assign push = out_en && (!hold_valid || pop);

    assign out_full   = hold_valid;
    assign disp_valid = hold_valid;
    assign out_count  = {3'b000, hold_valid};

    // Single holding register; a push wins over a simultaneous pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid <= 1'b0;
            disp_data  <= '0;
        end else if (push) begin
            hold_valid <= 1'b1;
            disp_data  <= out_data;
        end else if (pop) begin
            hold_valid <= 1'b0;
            disp_data  <= '0;
        end
    end

`endif

endmodule

// File: tb/tb_simple_io_port.sv
// tb_simple_io_port: directed self-checking bench for simple_io_port.
// Expected values adapt to the IO_OUT_FIFO_EN build option.

module tb_simple_io_port;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned DEBOUNCE = 7;
`ifdef IO_OUT_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        out_en   = 1'b0;
    logic [15:0] out_data = '0;
    logic        out_full;
    logic        overflow;
    logic        in_req   = 1'b0;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] sw       = '0;
    logic        next_btn = 1'b0;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic [3:0]  out_count;

    int checks   = 0;
    int failures = 0;
    int early    = 0;

    simple_io_port #(
        .DEPTH    (DEPTH),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .out_en     (out_en),
        .out_data   (out_data),
        .out_full   (out_full),
        .overflow   (overflow),
        .in_req     (in_req),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .sw         (sw),
        .next_btn   (next_btn),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .out_count  (out_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic out_push(input logic [15:0] d);
        out_en   = 1'b1;
        out_data = d;
        tick();
        out_en   = 1'b0;
    endtask

    // Clean press held long enough for one pop, then a clean release.
    task automatic pop_once();
        next_btn = 1'b1;
        repeat (11) tick();
        next_btn = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) tick();
        chk("rst_count", 16'(out_count), 16'd0);
        chk("rst_full", 16'(out_full), 16'd0);
        chk("rst_ovf", 16'(overflow), 16'd0);
        chk("rst_disp", disp_data, 16'h0000);
        chk("rst_dvalid", 16'(disp_valid), 16'd0);
        chk("rst_in_valid", 16'(in_valid), 16'd0);
        chk("rst_in_data", in_data, 16'h0000);
        reset = 1'b0;
        tick();

        // Fill
        if (FIFO) begin
            out_push(16'h0011);
            out_push(16'h0022);
            out_push(16'h0033);
            chk("fill3_count", 16'(out_count), 16'd3);
            chk("fill3_disp", disp_data, 16'h0011);
            chk("fill3_dvalid", 16'(disp_valid), 16'd1);
            chk("fill3_full", 16'(out_full), 16'd0);
            out_push(16'h0044);
            chk("fill4_count", 16'(out_count), 16'd4);
            chk("fill4_full", 16'(out_full), 16'd1);
        end else begin
            out_push(16'h0011);
            chk("fill1_count", 16'(out_count), 16'd1);
            chk("fill1_disp", disp_data, 16'h0011);
            chk("fill1_dvalid", 16'(disp_valid), 16'd1);
            chk("fill1_full", 16'(out_full), 16'd1);
        end
        chk("fill_no_ovf", 16'(overflow), 16'd0);

        // OUT while full with no pop: dropped, sticky overflow
        out_push(16'h00FF);
        chk("ovf_set", 16'(overflow), 16'd1);
        chk("ovf_disp", disp_data, 16'h0011);
        chk("ovf_count", 16'(out_count), FIFO ? 16'd4 : 16'd1);
        chk("ovf_full", 16'(out_full), 16'd1);

        // Push in the exact cycle pop_req fires (pop_req high after 10 edges)
        next_btn = 1'b1;
        repeat (10) tick();
        out_en   = 1'b1;
        out_data = 16'h0055;
        tick();
        out_en   = 1'b0;
        chk("pushpop_count", 16'(out_count), FIFO ? 16'd4 : 16'd1);
        chk("pushpop_disp", disp_data, FIFO ? 16'h0022 : 16'h0055);
        chk("pushpop_full", 16'(out_full), 16'd1);
        next_btn = 1'b0;
        repeat (12) tick();

        if (FIFO) begin
            pop_once();
            chk("pop1_disp", disp_data, 16'h0033);
            pop_once();
            chk("pop2_disp", disp_data, 16'h0044);
            pop_once();
            chk("pop3_disp", disp_data, 16'h0055);
            chk("pop3_full", 16'(out_full), 16'd0);
        end
        chk("one_left_count", 16'(out_count), 16'd1);

        // Bounce of 3-cycle pulses: no pop
        early = 0;
        for (int i = 0; i < 18; i++) begin
            next_btn = ((i / 3) % 2) == 0;
            tick();
            if (!disp_valid) early++;
        end
        chk("bounce_no_pop", 16'(early), 16'd0);
        chk("bounce_count", 16'(out_count), 16'd1);

        // Held stable: pop_req after 2+7+1 edges, display one edge later
        next_btn = 1'b1;
        repeat (10) tick();
        chk("press_not_early", 16'(disp_valid), 16'd1);
        tick();
        chk("press_pop_dvalid", 16'(disp_valid), 16'd0);
        chk("press_pop_disp", disp_data, 16'h0000);
        chk("press_pop_count", 16'(out_count), 16'd0);
        chk("press_pop_full", 16'(out_full), 16'd0);
        next_btn = 1'b0;
        repeat (12) tick();

        // Pop on empty is ignored
        next_btn = 1'b1;
        repeat (11) tick();
        chk("empty_pop_count", 16'(out_count), 16'd0);
        next_btn = 1'b0;
        repeat (12) tick();

        // Push on empty in the same cycle as pop_req: push wins
        next_btn = 1'b1;
        repeat (10) tick();
        out_en   = 1'b1;
        out_data = 16'h0077;
        tick();
        out_en   = 1'b0;
        chk("empty_pushpop_count", 16'(out_count), 16'd1);
        chk("empty_pushpop_disp", disp_data, 16'h0077);
        next_btn = 1'b0;
        repeat (12) tick();
        chk("release_no_pop", 16'(out_count), 16'd1);

        // IN path, back-to-back requests across a switch change
        sw = 16'hA5A5;
        repeat (3) tick();
        sw = 16'h5A5A;
        tick();
        in_req = 1'b1;
        tick();
        chk("in1_valid", 16'(in_valid), 16'd1);
        chk("in1_data", in_data, 16'hA5A5);
        tick();
        chk("in2_valid", 16'(in_valid), 16'd1);
        chk("in2_data", in_data, 16'h5A5A);
        in_req = 1'b0;
        tick();
        chk("in_end_valid", 16'(in_valid), 16'd0);
        chk("in_hold_data", in_data, 16'h5A5A);

        // Reset mid-debounce with entries queued
        out_push(16'h0088);
        chk("pre_rst_count", 16'(out_count), FIFO ? 16'd2 : 16'd1);
        next_btn = 1'b1;
        repeat (5) tick();
        reset    = 1'b1;
        next_btn = 1'b0;
        tick();
        chk("mid_rst_count", 16'(out_count), 16'd0);
        chk("mid_rst_full", 16'(out_full), 16'd0);
        chk("mid_rst_ovf", 16'(overflow), 16'd0);
        chk("mid_rst_disp", disp_data, 16'h0000);
        chk("mid_rst_dvalid", 16'(disp_valid), 16'd0);
        chk("mid_rst_in_valid", 16'(in_valid), 16'd0);
        chk("mid_rst_in_data", in_data, 16'h0000);
        reset = 1'b0;
        out_push(16'h1234);
        chk("post_rst_disp", disp_data, 16'h1234);
        chk("post_rst_count", 16'(out_count), 16'd1);
        chk("post_rst_full", 16'(out_full), FIFO ? 16'd0 : 16'd1);
        repeat (12) tick();
        chk("post_rst_no_pop", 16'(out_count), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
